// File: rtl/mux_seq_pkg.sv
// Shared encodings for the mux stimulus sequencer: FSM states and operand slot indices.
package mux_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_D = 2'd2;
  localparam logic [1:0] IDX_E = 2'd3;

endpackage

// File: rtl/mux_stim_sequencer_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the last count.
module dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Combinational so the capture happens on the same edge the count wraps.
  assign tick = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/mux_stim_sequencer.sv
// Loads four operands from a word stream, then sweeps the select value and
// captures the select stage's result once per dwell period.
module mux_stim_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned SEL_LAST = 15,
  parameter int unsigned DWELL    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  output logic [W-1:0]     d,
  output logic [W-1:0]     e,
  output logic [SEL_W-1:0] c,
  input  logic [W-1:0]     q_in,
  output logic [W-1:0]     res_data,
  output logic [SEL_W-1:0] res_sel,
  output logic             res_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [SEL_W-1:0] SEL_END = SEL_W'(SEL_LAST);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_idx;
  logic [W-1:0]     r_a, r_b, r_d, r_e;
  logic [SEL_W-1:0] r_c;
  logic [W-1:0]     r_res_data;
  logic [SEL_W-1:0] r_res_sel;
  logic             r_res_valid;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_xfer;
  logic             w_last_word;
  logic             w_last_sel;
  logic             w_tick;

  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_state != ST_SWEEP),
    .en   (r_state == ST_SWEEP),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xfer      = 1'b0;
    w_last_word = (r_idx == IDX_E);
    w_last_sel  = (r_c == SEL_END);
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_xfer = in_valid && r_in_ready;
        if (w_xfer && w_last_word) w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (w_tick && w_last_sel) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_d         <= '0;
      r_e         <= '0;
      r_c         <= '0;
      r_res_data  <= '0;
      r_res_sel   <= '0;
      r_res_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == ST_LOAD);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_res_valid <= 1'b0;

      if (r_state == ST_IDLE) begin
        r_idx <= '0;
      end

      if (w_xfer) begin
        case (r_idx)
          IDX_A:   r_a <= in_data;
          IDX_B:   r_b <= in_data;
          IDX_D:   r_d <= in_data;
          default: r_e <= in_data;
        endcase
        r_idx <= r_idx + 2'd1;
        if (w_last_word) r_c <= '0;
      end

      // The last select value is held; the sweep never wraps.
      if (w_tick) begin
        r_res_data  <= q_in;
        r_res_sel   <= r_c;
        r_res_valid <= 1'b1;
        if (!w_last_sel) r_c <= r_c + SEL_W'(1);
      end

      if (r_state == ST_DONE) begin
        r_c <= '0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign a         = r_a;
  assign b         = r_b;
  assign d         = r_d;
  assign e         = r_e;
  assign c         = r_c;
  assign res_data  = r_res_data;
  assign res_sel   = r_res_sel;
  assign res_valid = r_res_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mux_stim_sequencer.sv
// Directed bench for mux_stim_sequencer: default sweep (DWELL=4, SEL_LAST=15)
// on one instance and a short sweep (DWELL=2, SEL_LAST=8) on a second.
module tb_mux_stim_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = 4;

  // Select stage model: operand chosen by sel[1:0], flipped by sel[3:2].
  function automatic logic [W-1:0] stage(input logic [W-1:0] fa, fb, fd, fe,
                                         input logic [SW-1:0] s);
    logic [W-1:0] v;
    case (s[1:0])
      2'd0:    v = fa;
      2'd1:    v = fb;
      2'd2:    v = fd;
      default: v = fe;
    endcase
    return v ^ {2'b00, s[3:2]};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          sel;

  logic          start1, start2, iv1, iv2;
  logic          ir1, ir2, rv1, rv2, bz1, bz2, dn1, dn2;
  logic [W-1:0]  a1, b1, d1, e1, a2, b2, d2, e2;
  logic [W-1:0]  q1, q2, rd1, rd2;
  logic [SW-1:0] c1, c2, rs1, rs2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign iv1    = in_valid & ~sel;
  assign iv2    = in_valid & sel;
  assign q1     = stage(a1, b1, d1, e1, c1);
  assign q2     = stage(a2, b2, d2, e2, c2);

  mux_stim_sequencer u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(in_data), .in_valid(iv1),
    .in_ready(ir1), .a(a1), .b(b1), .d(d1), .e(e1), .c(c1), .q_in(q1),
    .res_data(rd1), .res_sel(rs1), .res_valid(rv1), .busy(bz1), .done(dn1)
  );

  mux_stim_sequencer #(
    .W(W), .SEL_W(SW), .SEL_LAST(8), .DWELL(2)
  ) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_data(in_data), .in_valid(iv2),
    .in_ready(ir2), .a(a2), .b(b2), .d(d2), .e(e2), .c(c2), .q_in(q2),
    .res_data(rd2), .res_sel(rs2), .res_valid(rv2), .busy(bz2), .done(dn2)
  );

  // View of whichever instance is under test.
  logic          m_ir, m_rv, m_bz, m_dn;
  logic [W-1:0]  m_a, m_b, m_d, m_e, m_rd;
  logic [SW-1:0] m_c, m_rs;
  assign m_ir = sel ? ir2 : ir1;
  assign m_rv = sel ? rv2 : rv1;
  assign m_bz = sel ? bz2 : bz1;
  assign m_dn = sel ? dn2 : dn1;
  assign m_a  = sel ? a2  : a1;
  assign m_b  = sel ? b2  : b1;
  assign m_d  = sel ? d2  : d1;
  assign m_e  = sel ? e2  : e1;
  assign m_rd = sel ? rd2 : rd1;
  assign m_c  = sel ? c2  : c1;
  assign m_rs = sel ? rs2 : rs1;

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ops"},       {m_a, m_b, m_d, m_e}, 32'd0);
    check({tag, "_c"},         32'(m_c), 32'd0);
    check({tag, "_res"},       {m_rd, m_rs}, 32'd0);
    check({tag, "_flags"},     {m_ir, m_rv, m_bz, m_dn}, 32'd0);
  endtask

  // Start, then stream four operands with `gap` idle cycles between valid words.
  task automatic do_load(input logic [3:0][W-1:0] v, input int gap, input bit hold_start);
    int  k;
    int  rdy;
    int  cyc;
    bit  fire;
    k   = 0;
    rdy = 0;
    cyc = 0;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    while (k < 4 && cyc < 200) begin
      if (m_ir) rdy++;
      in_valid = ((cyc % (gap + 1)) == 0);
      in_data  = in_valid ? v[k] : 4'hF;
      fire     = in_valid && m_ir;
      step();
      if (fire) k++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("load_words",      32'(k), 32'd4);
    check("in_ready_cycles", 32'(rdy), 32'(4 * (gap + 1) - gap));
    check("op_a", 32'(m_a), 32'(v[0]));
    check("op_b", 32'(m_b), 32'(v[1]));
    check("op_d", 32'(m_d), 32'(v[2]));
    check("op_e", 32'(m_e), 32'(v[3]));
    check("sweep_entry", {m_ir, m_bz, m_c}, {26'd0, 1'b0, 1'b1, 4'd0});
  endtask

  // Follow a full sweep; pulses must arrive every `dwell` cycles with matching sel/data.
  task automatic do_sweep(input logic [3:0][W-1:0] v, input int last, input int dwell);
    int pulses;
    int since;
    int cmax;
    int dones;
    int budget;
    pulses = 0;
    since  = 0;
    cmax   = 0;
    dones  = 0;
    budget = (last + 1) * dwell + 20;
    for (int cyc = 0; cyc < budget && dones == 0; cyc++) begin
      step();
      since++;
      if (int'(m_c) > cmax) cmax = int'(m_c);
      if (m_rv) begin
        check("res_sel",    32'(m_rs), 32'(pulses));
        check("res_data",   32'(m_rd), 32'(stage(v[0], v[1], v[2], v[3], SW'(pulses))));
        check("pulse_gap",  32'(since), 32'(dwell));
        check("done_align", 32'(m_dn), 32'(pulses == last));
        pulses++;
        since = 0;
      end else if (m_dn) begin
        check("done_without_pulse", 32'd1, 32'd0);
      end
      if (m_dn) begin
        dones++;
        start = 1'b0;
      end
    end
    check("pulse_count", 32'(pulses), 32'(last + 1));
    check("done_seen",   32'(dones), 32'd1);
    check("c_max",       32'(cmax), 32'(last));
    step();
    check("idle_flags",  {m_bz, m_dn, m_rv, m_ir}, 32'd0);
    check("idle_c",      32'(m_c), 32'd0);
    step();
    check("idle_stays",  32'(m_bz), 32'd0);
    check("ops_kept",    {m_a, m_b, m_d, m_e}, {16'd0, v[0], v[1], v[2], v[3]});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    sel      = 1'b0;
    step();
    step();
    check_cleared("reset1");
    sel = 1'b1;
    #1;
    check_cleared("reset2");
    sel = 1'b0;
    rst = 1'b0;
    step();

    // Plain load and full default sweep.
    do_load({4'd14, 4'd13, 4'd11, 4'd10}, 0, 1'b0);
    do_sweep({4'd14, 4'd13, 4'd11, 4'd10}, 15, 4);

    // Stalled load, then reset in the middle of the sweep.
    do_load({4'd4, 4'd3, 4'd2, 4'd1}, 2, 1'b0);
    repeat (9) step();
    check("mid_sweep_busy", 32'(m_bz), 32'd1);
    check("mid_sweep_res",  {m_rs, m_rd}, {24'd0, 4'd1, stage(4'd1, 4'd2, 4'd3, 4'd4, 4'd1)});
    rst = 1'b1;
    step();
    step();
    check_cleared("rst_mid");
    rst = 1'b0;
    step();

    // start held through load and sweep must not disturb anything.
    do_load({4'd8, 4'd7, 4'd6, 4'd5}, 0, 1'b1);
    do_sweep({4'd8, 4'd7, 4'd6, 4'd5}, 15, 4);

    // Short configuration on the second instance.
    sel = 1'b1;
    #1;
    check("dut2_idle", 32'(m_bz), 32'd0);
    do_load({4'd6, 4'd12, 4'd3, 4'd9}, 1, 1'b0);
    do_sweep({4'd6, 4'd12, 4'd3, 4'd9}, 8, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
